// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported, fixed-latency memory between the instruction-fetch
// port (if_*) and the data port (d_*). Each access is serialised through an
// IDLE -> ACCESS (LATENCY cycles) -> RESP sequence. Data requests have
// priority, but after STARVE_LIMIT consecutive data grants taken while a fetch
// was waiting, the fetch is served next.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   if_req/if_addr  fetch request and address
//   if_rdata        fetched word, registered, held until the next fetch read
//   if_ready        one-cycle completion pulse for the fetch port
//   if_stall        if_req & ~if_ready
//   d_rd/d_wr       data read / write request (both high = write)
//   d_addr/d_wdata  data address and write data
//   d_rdata         read data, registered, held until the next data read
//   d_ready         one-cycle completion pulse for the data port
//   mem_stall       (d_rd | d_wr) & ~d_ready
//   mem_en/mem_we   memory enable / write enable
//   mem_addr        memory address
//   mem_wdata       memory write data
//   mem_rdata       memory read data, valid in the LATENCY-th enable cycle
//   owner_d         current/last grant: 1 = data port, 0 = fetch port
module mem_port_arbiter #(
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_stall,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        owner_d
);

  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATENCY - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state;
  state_t stateNext;

  // Transaction latched at grant time; held for the whole ACCESS/RESP window
  logic             ownerQ;
  logic             wrQ;
  logic [31:0]      addrQ;
  logic [31:0]      wdataQ;
  logic [LAT_W-1:0] latCnt;
  logic [STV_W-1:0] starveCnt;

  logic dReq;
  logic starved;
  logic grantD;
  logic grantIf;
  logic latLast;

  // Arbitration: data wins unless the fetch port has been passed over
  // STARVE_LIMIT times in a row while it was waiting.
  assign dReq    = d_rd | d_wr;
  assign starved = if_req & (starveCnt == STV_MAX);
  assign grantD  = dReq & ~starved;
  assign grantIf = if_req & ~grantD;
  assign latLast = (latCnt == LAT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    stateNext = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    if_ready  = 1'b0;
    d_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (grantD || grantIf) begin
          stateNext = ACCESS;
        end
      end
      ACCESS: begin
        mem_en = 1'b1;
        mem_we = wrQ;
        if (latLast) begin
          stateNext = RESP;
        end
      end
      RESP: begin
        if_ready  = ~ownerQ;
        d_ready   = ownerQ;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Grant capture and latency counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ownerQ <= 1'b0;
      wrQ    <= 1'b0;
      addrQ  <= '0;
      wdataQ <= '0;
      latCnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grantD) begin
            ownerQ <= 1'b1;
            wrQ    <= d_wr;     // d_rd & d_wr resolves to a write
            addrQ  <= d_addr;
            wdataQ <= d_wdata;
            latCnt <= '0;
          end else if (grantIf) begin
            ownerQ <= 1'b0;
            wrQ    <= 1'b0;
            addrQ  <= if_addr;
            wdataQ <= '0;
            latCnt <= '0;
          end
        end
        ACCESS: begin
          latCnt <= latCnt + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Starvation counter: counts data grants made while a fetch was waiting,
  // saturating at STARVE_LIMIT; any fetch grant clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starveCnt <= '0;
    end else if (state == IDLE) begin
      if (grantD) begin
        if (if_req && (starveCnt != STV_MAX)) begin
          starveCnt <= starveCnt + 1'b1;
        end
      end else if (grantIf) begin
        starveCnt <= '0;
      end
    end
  end

  // Read data capture in the final ACCESS cycle; writes leave both untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata <= '0;
      d_rdata  <= '0;
    end else if ((state == ACCESS) && latLast && !wrQ) begin
      if (ownerQ) begin
        d_rdata <= mem_rdata;
      end else begin
        if_rdata <= mem_rdata;
      end
    end
  end

  assign mem_addr  = addrQ;
  assign mem_wdata = wdataQ;
  assign owner_d   = ownerQ;

  // Ready is state-decoded, so these stay free of combinational loops
  assign if_stall  = if_req & ~if_ready;
  assign mem_stall = dReq & ~d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int LAT = 2;
  localparam int SL  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        if_stall;
  logic        d_rd;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_stall;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        owner_d;

  mem_port_arbiter #(.LATENCY(LAT), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ready(if_ready), .if_stall(if_stall),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .mem_stall(mem_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner_d(owner_d)
  );

  always #5 clk = ~clk;

  // Memory emulator: 128 words, data valid only in the LAT-th enable cycle
  logic [31:0] memArr [0:127];
  int unsigned enRun = 0;
  logic        memLoad;
  logic [6:0]  loadIdx;
  logic [31:0] loadVal;

  always @(posedge clk) begin
    if (memLoad) memArr[loadIdx] <= loadVal;
    else if (mem_en && mem_we) memArr[mem_addr[8:2]] <= mem_wdata;
    enRun <= mem_en ? enRun + 1 : 0;
  end

  assign mem_rdata = (mem_en && enRun == LAT - 1) ? memArr[mem_addr[8:2]] : 32'hBAD0BAD0;

  // Transaction-level reference model
  logic [31:0] refMem [0:127];
  int          mPos;      // 0 idle, 1..LAT access, LAT+1 response
  int          mStarve;
  bit          mOwnerD, mWr;
  logic [31:0] mAddr, mWdata, expIf, expD;

  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    ifRdyCyc, dRdyCyc;
  int    stimMode = 0;    // 0 release, 1 always re-request, 2 random
  bit    prevEn = 0;
  bit    weSeen;
  string obsGrants;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkStr(input string tag, input string obs, input string exp);
    vectors++;
    assert (obs == exp) else begin
      miscompares++;
      $error("FAIL %s: got %s, expected %s", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] randAddr();
    logic [6:0] w;
    w = 7'($urandom_range(127));
    return {23'b0, w, 2'b00};
  endfunction

  task automatic newIf();
    if_req  = 1'b1;
    if_addr = randAddr();
  endtask

  task automatic newD(input bit readOnly);
    int r;
    r = readOnly ? 0 : $urandom_range(9);
    d_addr  = randAddr();
    d_wdata = $urandom;
    d_rd    = (r < 5) || (r == 9);
    d_wr    = (r >= 5);
  endtask

  task automatic step();
    bit expEn, expIfRdy, expDRdy;
    bit dReq;
    @(negedge clk);
    expEn    = (mPos >= 1) && (mPos <= LAT);
    expIfRdy = (mPos == LAT + 1) && !mOwnerD;
    expDRdy  = (mPos == LAT + 1) && mOwnerD;
    check("mem_en", 32'(mem_en), 32'(expEn));
    check("mem_we", 32'(mem_we), 32'(expEn && mWr));
    check("if_ready", 32'(if_ready), 32'(expIfRdy));
    check("d_ready", 32'(d_ready), 32'(expDRdy));
    check("if_stall", 32'(if_stall), 32'(if_req && !expIfRdy));
    check("mem_stall", 32'(mem_stall), 32'((d_rd || d_wr) && !expDRdy));
    check("if_rdata", if_rdata, expIf);
    check("d_rdata", d_rdata, expD);
    check("owner_d", 32'(owner_d), 32'(mOwnerD));
    if (expEn) check("mem_addr", mem_addr, mAddr);
    if (expEn && mWr) check("mem_wdata", mem_wdata, mWdata);
    if (if_ready) ifRdyCyc = cyc;
    if (d_ready) dRdyCyc = cyc;
    if (mem_we) weSeen = 1;
    if (mem_en && !prevEn) obsGrants = {obsGrants, owner_d ? "D" : "I"};
    prevEn = mem_en;

    // Advance the model across the coming edge
    dReq = d_rd || d_wr;
    if (rst) begin
      mPos = 0; mStarve = 0; mOwnerD = 0; expIf = '0; expD = '0;
    end else if (mPos == 0) begin
      if (dReq && !(if_req && mStarve == SL)) begin
        mOwnerD = 1; mWr = d_wr; mAddr = d_addr; mWdata = d_wdata;
        if (if_req && mStarve < SL) mStarve++;
        mPos = 1;
      end else if (if_req) begin
        mOwnerD = 0; mWr = 0; mAddr = if_addr;
        mStarve = 0;
        mPos = 1;
      end
    end else if (mPos <= LAT) begin
      mPos++;
      if (mPos == LAT + 1) begin
        if (mWr) refMem[mAddr[8:2]] = mWdata;
        else if (mOwnerD) expD = refMem[mAddr[8:2]];
        else expIf = refMem[mAddr[8:2]];
      end
    end else begin
      mPos = 0;
    end
    cyc++;

    @(posedge clk);
    #1;
    if (expIfRdy) if_req = 1'b0;
    if (expDRdy) begin d_rd = 1'b0; d_wr = 1'b0; end
    if (stimMode == 1) begin
      if (!if_req) newIf();
      if (!d_rd && !d_wr) newD(1);
    end else if (stimMode == 2) begin
      if (!if_req && $urandom_range(1) == 1) newIf();
      if (!d_rd && !d_wr && $urandom_range(1) == 1) newD(0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(mPos == 0 && !if_req && !d_rd && !d_wr) && n < 100) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(n < 100), 32'd1);
  endtask

  int start;
  logic [31:0] savedD;

  initial begin
    rst = 1; if_req = 0; if_addr = '0; d_rd = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
    memLoad = 1; loadIdx = '0; loadVal = '0;
    mPos = 0; mStarve = 0; mOwnerD = 0; mWr = 0; mAddr = '0; mWdata = '0;
    expIf = '0; expD = '0; ifRdyCyc = -1; dRdyCyc = -1; weSeen = 0; obsGrants = "";
    for (int i = 0; i < 128; i++) begin
      loadIdx = 7'(i);
      loadVal = (i == 16) ? 32'h8C010004 : $urandom;
      refMem[i] = loadVal;
      @(posedge clk); #1;
    end
    memLoad = 0;
    @(posedge clk); #1;

    // Reset state
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_if_ready", 32'(if_ready), 0);
    check("rst_d_ready", 32'(d_ready), 0);
    check("rst_owner_d", 32'(owner_d), 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst = 0;

    // Single fetch read
    if_req = 1; if_addr = 32'h40; start = cyc;
    drain();
    check("read_ready_cycle", 32'(ifRdyCyc - start), 3);
    check("read_if_rdata", if_rdata, 32'h8C010004);

    // Conflict: data first, fetch next
    if_req = 1; if_addr = randAddr(); d_rd = 1; d_addr = 32'h100; start = cyc;
    drain();
    check("conflict_d_cycle", 32'(dRdyCyc - start), 3);
    check("conflict_if_cycle", 32'(ifRdyCyc - start), 7);

    // Write, then read back
    savedD = d_rdata; weSeen = 0;
    d_wr = 1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF; start = cyc;
    drain();
    check("write_d_cycle", 32'(dRdyCyc - start), 3);
    check("write_we_seen", 32'(weSeen), 1);
    check("write_rdata_kept", d_rdata, savedD);
    d_rd = 1; d_addr = 32'h20;
    drain();
    check("readback", d_rdata, 32'hDEADBEEF);

    // Starvation guard: grant order with both ports continuously busy
    rst = 1; step(); rst = 0;
    obsGrants = ""; prevEn = 0;
    newIf(); newD(1); stimMode = 1;
    for (int i = 0; i < 6 * (LAT + 2); i++) step();
    checkStr("starve_order", obsGrants, "DDIDDI");
    stimMode = 0;
    drain();

    // Reset in the middle of ACCESS
    if_req = 1; if_addr = 32'h40;
    ifRdyCyc = -1;
    step(); step();
    rst = 1; if_req = 0;
    step();
    rst = 0;
    step(); step(); step();
    check("abort_no_ready", 32'(ifRdyCyc), 32'hFFFFFFFF);
    check("abort_if_rdata", if_rdata, 0);
    if_req = 1; if_addr = 32'h40; start = cyc;
    drain();
    check("post_rst_cycle", 32'(ifRdyCyc - start), 3);
    check("post_rst_rdata", if_rdata, 32'h8C010004);

    // Illegal d_rd & d_wr acts as a write
    savedD = d_rdata; weSeen = 0;
    d_rd = 1; d_wr = 1; d_addr = 32'h80; d_wdata = $urandom; start = cyc;
    drain();
    check("illegal_we", 32'(weSeen), 1);
    check("illegal_d_cycle", 32'(dRdyCyc - start), 3);
    check("illegal_rdata_kept", d_rdata, savedD);

    // Randomized traffic against the model
    stimMode = 2;
    for (int i = 0; i < 600; i++) step();
    stimMode = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
